// File: rtl/rem_sym_scheduler_pkg.sv
// Shared REM definitions: scheduler FSM encoding, RB/slot geometry and a
// helper that turns an RB count into a subcarrier count.
package rem_sym_scheduler_pkg;

  localparam int SC_PER_RB     = 12;
  localparam int SYMS_PER_SLOT = 14;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_WAIT_SRC = 3'd2,
    ST_READ     = 3'd3,
    ST_SYM_END  = 3'd4
  } state_t;

  // Subcarriers covered by n_rb resource blocks; 127 RBs -> 1524, fits 12 bits.
  function automatic logic [11:0] rb_to_sc(input logic [6:0] n_rb);
    return 12'(n_rb) * 12'(SC_PER_RB);
  endfunction

endpackage

// File: rtl/rem_addr_gen.sv
// Address generator: per-symbol subcarrier counter k, the slot-wide DMRS
// read counter and the one-cycle pipeline that lines the write address up
// with source data returning one cycle after the read.
module rem_addr_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmrs_clr,
  input  logic        k_clr,
  input  logic        read_active,
  input  logic        is_dmrs,
  input  logic [11:0] len,
  input  logic [11:0] base,
  output logic        fft_rd_en,
  output logic [10:0] fft_addr,
  output logic        dmrs_rd_en,
  output logic [9:0]  dmrs_addr,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic        sel_dmrs,
  output logic        k_done
);

  logic [11:0] k;
  logic [9:0]  dmrs_cnt;
  logic        rd_en;
  logic [11:0] wr_sum;
  logic        unused_wr_msb;

  // One read per cycle while k < len; the extra READ cycle at k == len only
  // drains the last write.
  assign rd_en      = read_active && (k < len);
  assign k_done     = (k == len);
  assign fft_rd_en  = rd_en && !is_dmrs;
  assign dmrs_rd_en = rd_en && is_dmrs;
  assign fft_addr   = fft_rd_en ? k[10:0] : 11'd0;
  assign dmrs_addr  = dmrs_rd_en ? dmrs_cnt : 10'd0;

  // 12-bit intermediate; the configuration check keeps it below 2048.
  assign wr_sum        = base + k;
  assign unused_wr_msb = wr_sum[11];

  // Counters and write-alignment pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k        <= 12'd0;
      dmrs_cnt <= 10'd0;
      wr_en    <= 1'b0;
      wr_addr  <= 11'd0;
      sel_dmrs <= 1'b0;
    end else begin
      if (k_clr)
        k <= 12'd0;
      else if (rd_en)
        k <= k + 12'd1;
      // DMRS reads run on across DMRS symbols and wrap 1023 -> 0.
      if (dmrs_clr)
        dmrs_cnt <= 10'd0;
      else if (dmrs_rd_en)
        dmrs_cnt <= dmrs_cnt + 10'd1;
      wr_en    <= rd_en;
      wr_addr  <= rd_en ? wr_sum[10:0] : 11'd0;
      sel_dmrs <= dmrs_rd_en;
    end
  end

endmodule

// File: rtl/rem_sym_scheduler.sv
// REM symbol scheduler: validates a slot configuration, then per symbol
// waits for the source memory and the ping-pong bank, streams 12*N_rb reads
// and issues the matching zero-padded bank writes one cycle later.
// Strobe timing: a read strobe (FFT_Rd_En / DMRS_Rd_En) in cycle n is always
// followed by Wr_En with its Wr_addr/Sel_Dmrs in cycle n+1; there is no
// back-pressure once a symbol has started.
module rem_sym_scheduler
  import rem_sym_scheduler_pkg::*;
#(
  parameter int MEM_DEPTH        = 2048,
  parameter int WRITE_ADDR_SHIFT = 424
) (
  input  logic        CLK_RE,
  input  logic        RST_RE,
  input  logic        Start,
  input  logic [10:0] N_sc,
  input  logic [6:0]  N_rb,
  input  logic [3:0]  Sym_Start,
  input  logic [3:0]  Sym_End,
  input  logic [13:0] Dmrs_Pos,
  input  logic        FFT_Done,
  input  logic        DMRS_Done,
  input  logic        Buf_Ready,
  output logic [10:0] FFT_addr,
  output logic        FFT_Rd_En,
  output logic [9:0]  DMRS_addr,
  output logic        DMRS_Rd_En,
  output logic [10:0] Wr_addr,
  output logic        Wr_En,
  output logic        Sel_Dmrs,
  output logic [3:0]  Sym_Idx,
  output logic        Sym_Done,
  output logic        Slot_Done,
  output logic        Busy,
  output logic        Cfg_Err,
  output logic [2:0]  fsm_state
);

  state_t      state, next_state;
  logic [10:0] cfg_n_sc;
  logic [6:0]  cfg_n_rb;
  logic [3:0]  cfg_sym_start;
  logic [3:0]  cfg_sym_end;
  logic [13:0] cfg_dmrs;
  logic [3:0]  sym_idx;
  logic        cfg_err_q;

  logic [11:0] cfg_len;
  logic [11:0] wr_base;
  logic [12:0] need;
  logic        cfg_bad;
  logic [15:0] dmrs_ext;
  logic        is_dmrs;
  logic        src_ok;
  logic        last_sym;
  logic        k_done;

  assign cfg_len  = rb_to_sc(cfg_n_rb);
  assign wr_base  = 12'(WRITE_ADDR_SHIFT) + 12'(cfg_n_sc);
  assign need     = 13'(WRITE_ADDR_SHIFT) + 13'(cfg_n_sc) + 13'(cfg_len);
  assign cfg_bad  = (cfg_n_rb == 7'd0) || (cfg_sym_start > cfg_sym_end) ||
                    (cfg_sym_end > 4'(SYMS_PER_SLOT - 1)) ||
                    (need > 13'(MEM_DEPTH));
  assign dmrs_ext = {2'b00, cfg_dmrs};
  assign is_dmrs  = dmrs_ext[sym_idx];
  assign src_ok   = is_dmrs ? DMRS_Done : FFT_Done;
  assign last_sym = (sym_idx >= cfg_sym_end);

  assign Sym_Idx   = sym_idx;
  assign Cfg_Err   = cfg_err_q;
  assign fsm_state = state;

  // State register.
  always_ff @(posedge CLK_RE) begin
    if (!RST_RE)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // Next-state and status outputs; a symbol leaves READ only on k_done, so
  // flags dropping mid-symbol cannot interrupt it.
  always_comb begin
    next_state = state;
    Busy       = (state != ST_IDLE);
    Sym_Done   = 1'b0;
    Slot_Done  = 1'b0;
    case (state)
      ST_IDLE:     if (Start) next_state = ST_CHECK;
      ST_CHECK:    next_state = cfg_bad ? ST_IDLE : ST_WAIT_SRC;
      ST_WAIT_SRC: if (Buf_Ready && src_ok) next_state = ST_READ;
      ST_READ:     if (k_done) next_state = ST_SYM_END;
      ST_SYM_END: begin
        Sym_Done   = 1'b1;
        Slot_Done  = last_sym;
        next_state = last_sym ? ST_IDLE : ST_WAIT_SRC;
      end
      default:     next_state = ST_IDLE;
    endcase
  end

  // Configuration capture, symbol index and the one-cycle error flag.
  always_ff @(posedge CLK_RE) begin
    if (!RST_RE) begin
      cfg_n_sc      <= 11'd0;
      cfg_n_rb      <= 7'd0;
      cfg_sym_start <= 4'd0;
      cfg_sym_end   <= 4'd0;
      cfg_dmrs      <= 14'd0;
      sym_idx       <= 4'd0;
      cfg_err_q     <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            cfg_n_sc      <= N_sc;
            cfg_n_rb      <= N_rb;
            cfg_sym_start <= Sym_Start;
            cfg_sym_end   <= Sym_End;
            cfg_dmrs      <= Dmrs_Pos;
          end
        end
        ST_CHECK: begin
          if (cfg_bad)
            cfg_err_q <= 1'b1;
          else
            sym_idx <= cfg_sym_start;
        end
        ST_SYM_END: begin
          if (!last_sym)
            sym_idx <= sym_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  rem_addr_gen u_addr_gen (
    .clk         (CLK_RE),
    .rst_n       (RST_RE),
    .dmrs_clr    ((state == ST_IDLE) && Start),
    .k_clr       (state == ST_WAIT_SRC),
    .read_active (state == ST_READ),
    .is_dmrs     (is_dmrs),
    .len         (cfg_len),
    .base        (wr_base),
    .fft_rd_en   (FFT_Rd_En),
    .fft_addr    (FFT_addr),
    .dmrs_rd_en  (DMRS_Rd_En),
    .dmrs_addr   (DMRS_addr),
    .wr_en       (Wr_En),
    .wr_addr     (Wr_addr),
    .sel_dmrs    (Sel_Dmrs),
    .k_done      (k_done)
  );

endmodule

// File: tb/tb_rem_sym_scheduler.sv
// Bench for rem_sym_scheduler: table of slot configurations with
// hand-computed results, plus directed stall, flag-drop, busy-Start and
// mid-READ reset sequences.
module tb_rem_sym_scheduler;

  logic        CLK_RE = 1'b0;
  logic        RST_RE;
  logic        Start;
  logic [10:0] N_sc;
  logic [6:0]  N_rb;
  logic [3:0]  Sym_Start, Sym_End;
  logic [13:0] Dmrs_Pos;
  logic        FFT_Done, DMRS_Done, Buf_Ready;
  logic [10:0] FFT_addr;
  logic        FFT_Rd_En;
  logic [9:0]  DMRS_addr;
  logic        DMRS_Rd_En;
  logic [10:0] Wr_addr;
  logic        Wr_En, Sel_Dmrs;
  logic [3:0]  Sym_Idx;
  logic        Sym_Done, Slot_Done, Busy, Cfg_Err;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  // {Sel_Dmrs, Wr_addr} expected one cycle after each read.
  logic [11:0] exp_q[$];

  typedef struct {
    logic [10:0] n_sc;
    logic [6:0]  n_rb;
    logic [3:0]  sym_start;
    logic [3:0]  sym_end;
    logic [13:0] dmrs_pos;
    bit          exp_err;
    int          exp_syms;
    int          exp_last_wr;
  } cfg_t;

  localparam int NVEC = 10;
  cfg_t vec[NVEC];

  rem_sym_scheduler dut (
    .CLK_RE     (CLK_RE),
    .RST_RE     (RST_RE),
    .Start      (Start),
    .N_sc       (N_sc),
    .N_rb       (N_rb),
    .Sym_Start  (Sym_Start),
    .Sym_End    (Sym_End),
    .Dmrs_Pos   (Dmrs_Pos),
    .FFT_Done   (FFT_Done),
    .DMRS_Done  (DMRS_Done),
    .Buf_Ready  (Buf_Ready),
    .FFT_addr   (FFT_addr),
    .FFT_Rd_En  (FFT_Rd_En),
    .DMRS_addr  (DMRS_addr),
    .DMRS_Rd_En (DMRS_Rd_En),
    .Wr_addr    (Wr_addr),
    .Wr_En      (Wr_En),
    .Sel_Dmrs   (Sel_Dmrs),
    .Sym_Idx    (Sym_Idx),
    .Sym_Done   (Sym_Done),
    .Slot_Done  (Slot_Done),
    .Busy       (Busy),
    .Cfg_Err    (Cfg_Err),
    .fsm_state  (fsm_state)
  );

  // Clock.
  always #5 CLK_RE = ~CLK_RE;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {fsm_state, FFT_addr, FFT_Rd_En, DMRS_addr, DMRS_Rd_En, Wr_addr,
                 Wr_En, Sel_Dmrs, Sym_Idx, Sym_Done, Slot_Done, Busy, Cfg_Err}, 64'd0);
  endtask

  // Starts one slot (caller is just past a negedge) and follows it to the
  // end. stall: Buf_Ready held low for that many extra cycles; drop_at:
  // flags fall after that many reads; poke_at: a Start with junk config is
  // pulsed at that cycle while busy.
  task automatic run_slot(input cfg_t c, input int stall, input int drop_at, input int poke_at);
    int          k, sym, syms, reads, first_rd, last_wr;
    bit          done, got_err, prev_wr, dmrs_sym;
    logic [11:0] base, len, e;
    logic [9:0]  exp_dmrs;
    exp_q.delete();
    base      = 12'd424 + 12'(c.n_sc);
    len       = 12'(c.n_rb) * 12'd12;
    N_sc      = c.n_sc;
    N_rb      = c.n_rb;
    Sym_Start = c.sym_start;
    Sym_End   = c.sym_end;
    Dmrs_Pos  = c.dmrs_pos;
    FFT_Done  = 1'b1;
    DMRS_Done = 1'b1;
    Buf_Ready = (stall == 0);
    Start     = 1'b1;
    k = 0; sym = int'(c.sym_start); syms = 0; reads = 0; first_rd = -1; last_wr = -1;
    done = 0; got_err = 0; prev_wr = 0; exp_dmrs = 10'd0;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge CLK_RE);
      if (t == 0) begin
        Start = 1'b0;
        check("busy_after_start", Busy, 1);
      end
      if (stall > 0 && t == stall + 1) Buf_Ready = 1'b1;
      if (poke_at > 0 && t == poke_at) begin
        Start = 1'b1; N_rb = 7'd0; Sym_End = 4'd0; Dmrs_Pos = 14'h3fff; N_sc = 11'h7ff;
      end
      if (poke_at > 0 && t == poke_at + 1) Start = 1'b0;
      if (Cfg_Err) begin
        got_err = 1;
        check("busy_on_cfg_err", Busy, 0);
        done = 1;
      end else begin
        if (Wr_En) begin
          if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("wr_sel_addr", {Sel_Dmrs, Wr_addr}, e);
            last_wr = int'(Wr_addr);
          end
        end else if (exp_q.size() != 0) begin
          check("wr_missing", 0, 1);
          exp_q.delete();
        end
        dmrs_sym = (sym < 14) ? c.dmrs_pos[sym] : 1'b0;
        if (FFT_Rd_En || DMRS_Rd_En) begin
          if (first_rd < 0) begin
            first_rd = t;
            check("first_read_cycle", t, (stall > 0) ? stall + 2 : 2);
          end
          check("rd_sym_idx", Sym_Idx, sym);
          if (dmrs_sym) begin
            check("dmrs_rd", {FFT_Rd_En, DMRS_Rd_En, DMRS_addr}, {1'b0, 1'b1, exp_dmrs});
            exp_dmrs++;
          end else begin
            check("fft_rd", {FFT_Rd_En, DMRS_Rd_En, FFT_addr}, {1'b1, 1'b0, 11'(k)});
          end
          e = {dmrs_sym, 11'(base + 12'(k))};
          exp_q.push_back(e);
          k++;
          reads++;
          if (drop_at > 0 && reads == drop_at) begin
            Buf_Ready = 1'b0; FFT_Done = 1'b0; DMRS_Done = 1'b0;
          end
        end
        if (Sym_Done) begin
          check("sym_len", k, len);
          check("sym_done_after_last_wr", {prev_wr, Wr_En}, 2'b10);
          check("slot_done", Slot_Done, (sym == int'(c.sym_end)));
          syms++;
          k = 0;
          sym++;
          if (drop_at > 0) begin
            Buf_Ready = 1'b1; FFT_Done = 1'b1; DMRS_Done = 1'b1;
          end
          if (Slot_Done) done = 1;
        end else if (Slot_Done) begin
          check("slot_done_without_sym_done", 1, 0);
        end
        prev_wr = Wr_En;
      end
    end
    if (!done) check("slot_timeout", 0, 1);
    check("cfg_err", got_err, c.exp_err);
    if (!c.exp_err) begin
      check("sym_count", syms, c.exp_syms);
      check("last_wr_addr", last_wr, c.exp_last_wr);
    end
    @(negedge CLK_RE);
    check("idle_after_slot", {Busy, Cfg_Err, Sym_Done, Slot_Done}, 0);
  endtask

  initial begin
    bit found;
    cfg_t rc;
    //             n_sc     n_rb    s_start s_end  dmrs      err  syms last_wr
    vec[0] = '{11'd0,   7'd1,   4'd0,  4'd0,  14'h0000, 1'b0, 1, 435};
    vec[1] = '{11'd0,   7'd2,   4'd2,  4'd4,  14'h0008, 1'b0, 3, 447};
    vec[2] = '{11'd5,   7'd1,   4'd0,  4'd2,  14'h0005, 1'b0, 3, 440};
    vec[3] = '{11'd0,   7'd106, 4'd13, 4'd13, 14'h2000, 1'b0, 1, 1695};
    vec[4] = '{11'd100, 7'd127, 4'd0,  4'd0,  14'h0001, 1'b0, 1, 2047};
    vec[5] = '{11'd101, 7'd127, 4'd0,  4'd0,  14'h0000, 1'b1, 0, 0};
    vec[6] = '{11'd1,   7'd0,   4'd0,  4'd0,  14'h0000, 1'b1, 0, 0};
    vec[7] = '{11'd0,   7'd1,   4'd5,  4'd4,  14'h0000, 1'b1, 0, 0};
    vec[8] = '{11'd0,   7'd1,   4'd0,  4'd14, 14'h0000, 1'b1, 0, 0};
    vec[9] = '{11'd2047,7'd1,   4'd0,  4'd0,  14'h0000, 1'b1, 0, 0};

    // Reset block.
    RST_RE = 1'b0; Start = 1'b0; N_sc = '0; N_rb = '0; Sym_Start = '0; Sym_End = '0;
    Dmrs_Pos = '0; FFT_Done = 1'b1; DMRS_Done = 1'b1; Buf_Ready = 1'b1;
    repeat (3) @(negedge CLK_RE);
    check_all_zero("reset_state");
    RST_RE = 1'b1;

    // Table: first entry starts in the very first cycle out of reset.
    for (int i = 0; i < NVEC; i++) run_slot(vec[i], 0, 0, 0);

    // Bank busy for 10 extra cycles at symbol start.
    run_slot(vec[0], 10, 0, 0);
    // Buf_Ready and source flags fall mid-READ.
    run_slot(vec[0], 0, 5, 0);
    // Start with junk configuration while busy.
    run_slot(vec[1], 0, 0, 6);

    // Reset at k=7 of symbol 1 (a DMRS symbol), then restart.
    rc = '{11'd0, 7'd1, 4'd0, 4'd1, 14'h0002, 1'b0, 2, 435};
    N_sc = rc.n_sc; N_rb = rc.n_rb; Sym_Start = rc.sym_start; Sym_End = rc.sym_end;
    Dmrs_Pos = rc.dmrs_pos; Start = 1'b1;
    found = 0;
    for (int t = 0; t < 60 && !found; t++) begin
      @(negedge CLK_RE);
      Start = 1'b0;
      if (DMRS_Rd_En && DMRS_addr == 10'd7 && Sym_Idx == 4'd1) found = 1;
    end
    check("reach_k7_sym1", found, 1);
    RST_RE = 1'b0;
    @(negedge CLK_RE);
    check_all_zero("reset_mid_read");
    RST_RE = 1'b1;
    run_slot(rc, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
